// File: rtl/seq_shift_unit.sv
// Iterative 32-bit shifter: one power-of-two stage (16, 8, 4, 2, 1) per clock,
// with valid/ready handshakes on both the request side and the result side.
module seq_shift_unit #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand,
    input  logic [4:0]  shamt,
    input  logic        lr_shift,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        acc;
    logic [4:0]         shamt_q;
    logic               dir_q;
    logic [2:0]         idx;
    logic [4:0]         stage_amt;
    logic [31:0]        acc_sll;
    logic signed [31:0] acc_sra;
    logic               accept;
    logic               bypass;

    assign accept    = in_valid && (state == IDLE);
    assign bypass    = ZERO_BYPASS && (shamt == 5'd0);
    assign stage_amt = 5'd1 << idx;
    assign acc_sll   = acc << stage_amt;
    // Kept in its own signed signal so >>> stays arithmetic and fills with acc[31].
    assign acc_sra   = $signed(acc) >>> stage_amt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bypass ? DONE : SHIFT;
            SHIFT:   if (idx == 3'd0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A stage whose shamt bit is clear leaves acc untouched but still spends its cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc     <= 32'd0;
            shamt_q <= 5'd0;
            dir_q   <= 1'b0;
            idx     <= 3'd0;
        end else if (accept) begin
            acc     <= operand;
            shamt_q <= shamt;
            dir_q   <= lr_shift;
            idx     <= 3'd4;
        end else if (state == SHIFT) begin
            if (shamt_q[idx]) begin
                acc <= dir_q ? acc_sra : acc_sll;
            end
            idx <= idx - 3'd1;
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: latency, shift results, bypass on/off,
// backpressure, requests ignored while busy, and reset abort.
module tb_seq_shift_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        lr_shift;
    logic        out_ready;
    logic        sel_nb;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [31:0] a_result;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [31:0] b_result;

    logic        o_in_ready, o_out_valid, o_busy;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seq_shift_unit #(.ZERO_BYPASS(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid && !sel_nb),
        .in_ready  (a_in_ready),
        .operand   (operand),
        .shamt     (shamt),
        .lr_shift  (lr_shift),
        .out_valid (a_out_valid),
        .out_ready (out_ready && !sel_nb),
        .result    (a_result),
        .busy      (a_busy)
    );

    seq_shift_unit #(.ZERO_BYPASS(1'b0)) dut_nb (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid && sel_nb),
        .in_ready  (b_in_ready),
        .operand   (operand),
        .shamt     (shamt),
        .lr_shift  (lr_shift),
        .out_valid (b_out_valid),
        .out_ready (out_ready && sel_nb),
        .result    (b_result),
        .busy      (b_busy)
    );

    assign o_in_ready  = sel_nb ? b_in_ready  : a_in_ready;
    assign o_out_valid = sel_nb ? b_out_valid : a_out_valid;
    assign o_busy      = sel_nb ? b_busy      : a_busy;
    assign o_result    = sel_nb ? b_result    : a_result;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request; it is accepted on the next edge (unit must be idle).
    task automatic start(input logic [31:0] op, input logic [4:0] sh, input logic dir);
        check("ready_before_req", {31'd0, o_in_ready}, 32'd1);
        in_valid = 1'b1;
        operand  = op;
        shamt    = sh;
        lr_shift = dir;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, bounded at 20.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int lat = 0;
        while (!o_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, o_result, exp_res);
        check({tag, "_busy_done"}, {31'd0, o_busy}, 32'd1);
        check({tag, "_ready_done"}, {31'd0, o_in_ready}, 32'd0);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_after"}, {31'd0, o_out_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, o_in_ready}, 32'd1);
        check({tag, "_busy_after"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        operand   = 32'd0;
        shamt     = 5'd0;
        lr_shift  = 1'b0;
        out_ready = 1'b0;
        sel_nb    = 1'b0;

        tick();
        tick();
        check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        reset = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);

        // LLS 1 by 31
        start(32'h0000_0001, 5'd31, 1'b0);
        check("lls31_busy_shift", {31'd0, o_busy}, 32'd1);
        wait_done("lls31", 5, 32'h8000_0000);
        handoff("lls31");

        // RAS cases
        start(32'h8000_0000, 5'd8, 1'b1);
        wait_done("ras8", 5, 32'hFF80_0000);
        handoff("ras8");
        start(32'h7FFF_FFFF, 5'd31, 1'b1);
        wait_done("ras31_pos", 5, 32'h0000_0000);
        handoff("ras31_pos");
        start(32'h8000_0001, 5'd31, 1'b1);
        wait_done("ras31_neg", 5, 32'hFFFF_FFFF);
        handoff("ras31_neg");
        start(32'hA5A5_A5A5, 5'd5, 1'b0);
        wait_done("lls5", 5, 32'hB4B4_B4A0);
        handoff("lls5");

        // Zero bypass on, then off
        start(32'hDEAD_BEEF, 5'd0, 1'b0);
        wait_done("bypass_on", 0, 32'hDEAD_BEEF);
        handoff("bypass_on");
        sel_nb = 1'b1;
        start(32'hDEAD_BEEF, 5'd0, 1'b0);
        wait_done("bypass_off", 5, 32'hDEAD_BEEF);
        handoff("bypass_off");
        sel_nb = 1'b0;

        // Backpressure: result and out_valid hold while out_ready is low
        start(32'h0000_F00F, 5'd4, 1'b0);
        wait_done("bp", 5, 32'h000F_00F0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, o_out_valid}, 32'd1);
            check("bp_hold_result", o_result, 32'h000F_00F0);
            check("bp_hold_ready", {31'd0, o_in_ready}, 32'd0);
        end
        handoff("bp");

        // Request held during SHIFT/DONE is ignored until after hand-off
        start(32'h0000_0001, 5'd3, 1'b0);
        in_valid = 1'b1;
        operand  = 32'h1234_5678;
        shamt    = 5'd4;
        lr_shift = 1'b0;
        check("busy_req_ready", {31'd0, o_in_ready}, 32'd0);
        wait_done("busy_req_orig", 5, 32'h0000_0008);
        handoff("busy_req_orig");
        tick();
        in_valid = 1'b0;
        check("busy_req_accepted", {31'd0, o_busy}, 32'd1);
        wait_done("busy_req_new", 5, 32'h2345_6780);
        handoff("busy_req_new");

        // Reset in the middle of a RAS aborts it
        start(32'hF000_0000, 5'd20, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("abort_result", o_result, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        reset = 1'b1;
        check("abort_in_ready", {31'd0, o_in_ready}, 32'd1);
        start(32'h0000_0003, 5'd1, 1'b0);
        wait_done("after_abort", 5, 32'h0000_0006);
        handoff("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
